// File: rtl/cnn_settle_monitor.sv
// Settling detector for the 4x4 cellular-network array: compares successive frames
// pixel by pixel and reports a binarized result once the array stops changing.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; last result still visible
// ARM     | waiting for the baseline frame
// WAIT    | waiting for the next frame
// COMPARE | 16 cycles, one pixel per cycle, cur vs prev
// DONE    | result valid, held until ack
module cnn_settle_monitor #(
  parameter int WIDTH         = 9,
  parameter int ITER_WIDTH    = 8,
  parameter int MAX_ITER      = 200,
  parameter int STABLE_FRAMES = 3,
  parameter int TOL           = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    frame_sync,
  input  logic signed [WIDTH-1:0] Y1_in,
  input  logic signed [WIDTH-1:0] Y2_in,
  input  logic signed [WIDTH-1:0] Y3_in,
  input  logic signed [WIDTH-1:0] Y4_in,
  input  logic signed [WIDTH-1:0] Y5_in,
  input  logic signed [WIDTH-1:0] Y6_in,
  input  logic signed [WIDTH-1:0] Y7_in,
  input  logic signed [WIDTH-1:0] Y8_in,
  input  logic signed [WIDTH-1:0] Y9_in,
  input  logic signed [WIDTH-1:0] Y10_in,
  input  logic signed [WIDTH-1:0] Y11_in,
  input  logic signed [WIDTH-1:0] Y12_in,
  input  logic signed [WIDTH-1:0] Y13_in,
  input  logic signed [WIDTH-1:0] Y14_in,
  input  logic signed [WIDTH-1:0] Y15_in,
  input  logic signed [WIDTH-1:0] Y16_in,
  input  logic                    ack,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic                    overrun,
  output logic [15:0]             bin_out,
  output logic [ITER_WIDTH-1:0]   iter_count
);

  localparam int SW = (STABLE_FRAMES < 1) ? 1 : $clog2(STABLE_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_cur  [16];
  logic signed [WIDTH-1:0] r_prev [16];
  logic [3:0]              r_idx;
  logic [SW-1:0]           r_stable;
  logic                    r_diff;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_timeout;
  logic                    r_overrun;
  logic [15:0]             r_bin;
  logic [ITER_WIDTH-1:0]   r_iter;

  logic signed [WIDTH-1:0] w_y [16];
  logic signed [WIDTH:0]   w_delta;
  logic [WIDTH:0]          w_mag;
  logic                    w_pix_diff;
  logic                    w_frame_diff;
  logic [SW-1:0]           w_stable_next;
  logic                    w_settled;
  logic                    w_max_iter;
  logic [15:0]             w_bin;

  assign w_y[0]  = Y1_in;
  assign w_y[1]  = Y2_in;
  assign w_y[2]  = Y3_in;
  assign w_y[3]  = Y4_in;
  assign w_y[4]  = Y5_in;
  assign w_y[5]  = Y6_in;
  assign w_y[6]  = Y7_in;
  assign w_y[7]  = Y8_in;
  assign w_y[8]  = Y9_in;
  assign w_y[9]  = Y10_in;
  assign w_y[10] = Y11_in;
  assign w_y[11] = Y12_in;
  assign w_y[12] = Y13_in;
  assign w_y[13] = Y14_in;
  assign w_y[14] = Y15_in;
  assign w_y[15] = Y16_in;

  // One extra bit keeps the full range: -256 vs +255 gives 511, never wraps.
  assign w_delta = {r_cur[r_idx][WIDTH-1], r_cur[r_idx]}
                 - {r_prev[r_idx][WIDTH-1], r_prev[r_idx]};
  assign w_mag   = w_delta[WIDTH] ? $unsigned(-w_delta) : $unsigned(w_delta);

  assign w_pix_diff    = (w_mag > (WIDTH+1)'(TOL));
  assign w_frame_diff  = r_diff | w_pix_diff;
  assign w_stable_next = w_frame_diff ? '0 : r_stable + SW'(1);
  assign w_settled     = (w_stable_next == SW'(STABLE_FRAMES));
  assign w_max_iter    = (r_iter == ITER_WIDTH'(MAX_ITER));

  always_comb begin
    w_bin = '0;
    for (int i = 0; i < 16; i++) begin
      w_bin[i] = ~r_cur[i][WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_stable  <= '0;
      r_diff    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
      r_bin     <= '0;
      r_iter    <= '0;
      for (int i = 0; i < 16; i++) begin
        r_cur[i]  <= '0;
        r_prev[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_ARM;
            r_busy    <= 1'b1;
            r_iter    <= '0;
            r_stable  <= '0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
          end
        end
        S_ARM: begin
          if (frame_sync) begin
            for (int i = 0; i < 16; i++) r_cur[i] <= w_y[i];
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (frame_sync) begin
            for (int i = 0; i < 16; i++) begin
              r_prev[i] <= r_cur[i];
              r_cur[i]  <= w_y[i];
            end
            r_iter  <= r_iter + ITER_WIDTH'(1);
            r_diff  <= 1'b0;
            r_idx   <= '0;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (frame_sync) r_overrun <= 1'b1;
          if (r_idx == 4'd15) begin
            r_stable <= w_stable_next;
            r_diff   <= w_frame_diff;
            // Settling wins over timeout when both land on the same frame.
            if (w_settled || w_max_iter) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_timeout <= ~w_settled;
              r_bin     <= w_bin;
            end else begin
              r_state <= S_WAIT;
            end
          end else begin
            r_diff <= w_frame_diff;
            r_idx  <= r_idx + 4'd1;
          end
        end
        S_DONE: begin
          if (ack) begin
            r_done <= 1'b0;
            if (start) begin
              r_state   <= S_ARM;
              r_busy    <= 1'b1;
              r_iter    <= '0;
              r_stable  <= '0;
              r_timeout <= 1'b0;
              r_overrun <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign overrun    = r_overrun;
  assign bin_out    = r_bin;
  assign iter_count = r_iter;

endmodule

// File: tb/tb_cnn_settle_monitor.sv
// Scoreboard bench for cnn_settle_monitor: each run pushes its hand-computed result,
// an independent monitor pops and checks it when done rises.
module tb_cnn_settle_monitor;

  localparam int W      = 9;
  localparam int IW     = 8;
  localparam int PERIOD = 20;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                fs = 1'b0;
  logic                ack = 1'b0;
  logic signed [W-1:0] y [16];
  logic                busy, done, timeout, overrun;
  logic [15:0]         bin_out;
  logic [IW-1:0]       iter_count;

  typedef struct {
    logic        to;
    int          iter;
    logic [15:0] bin;
    logic        ovr;
  } exp_t;

  exp_t sb[$];
  int   seq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_fs = 0;
  logic done_q = 1'b0;

  cnn_settle_monitor #(
    .WIDTH(W), .ITER_WIDTH(IW), .MAX_ITER(6), .STABLE_FRAMES(3), .TOL(2)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .frame_sync(fs),
    .Y1_in(y[0]),   .Y2_in(y[1]),   .Y3_in(y[2]),   .Y4_in(y[3]),
    .Y5_in(y[4]),   .Y6_in(y[5]),   .Y7_in(y[6]),   .Y8_in(y[7]),
    .Y9_in(y[8]),   .Y10_in(y[9]),  .Y11_in(y[10]), .Y12_in(y[11]),
    .Y13_in(y[12]), .Y14_in(y[13]), .Y15_in(y[14]), .Y16_in(y[15]),
    .ack(ack), .busy(busy), .done(done), .timeout(timeout), .overrun(overrun),
    .bin_out(bin_out), .iter_count(iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each done rising edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("timeout", {31'd0, timeout}, {31'd0, e.to});
          chk("iter_count", {24'd0, iter_count}, e.iter);
          chk("bin_out", {16'd0, bin_out}, {16'd0, e.bin});
          chk("overrun", {31'd0, overrun}, {31'd0, e.ovr});
          chk("latency", cyc - last_fs, 32'd17);
        end
      end
      done_q = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic set_all(input int v);
    for (int i = 0; i < 16; i++) y[i] = W'(v);
  endtask

  task automatic pulse_fs(input bit track);
    fs = 1'b1;
    if (track) last_fs = cyc;
    @(negedge clk);
    fs = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("done_after_ack", {31'd0, done}, 32'd0);
  endtask

  // One run: pixel pix follows seq, every other pixel holds base.
  task automatic run_pix(input int pix, input int base);
    int n = seq.size();
    do_start();
    for (int f = 0; f < n; f++) begin
      set_all(base);
      y[pix] = W'(seq[f]);
      pulse_fs(1'b1);
      if (f != n - 1) repeat (PERIOD - 1) @(negedge clk);
    end
    wait_done();
  endtask

  initial begin
    set_all(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_iter", {24'd0, iter_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Constant frames: settles on the 3rd comparison.
    sb.push_back('{to: 1'b0, iter: 3, bin: 16'hFFFF, ovr: 1'b0});
    seq = '{64, 64, 64, 64};
    run_pix(0, 64);
    do_ack();
    chk("iter_kept_idle", {24'd0, iter_count}, 32'd3);

    // Y7 swings across the full range every frame; never settles.
    sb.push_back('{to: 1'b1, iter: 6, bin: 16'hFFBF, ovr: 1'b0});
    seq = '{-256, 255, -256, 255, -256, 255, -256};
    run_pix(6, 64);
    do_ack();

    // Y3 within tolerance of 2.
    sb.push_back('{to: 1'b0, iter: 3, bin: 16'hFFFF, ovr: 1'b0});
    seq = '{10, 12, 10, 12};
    run_pix(2, 64);
    do_ack();

    // Y3 jumps by 3 on the third comparison; settles exactly at the iteration limit.
    sb.push_back('{to: 1'b0, iter: 6, bin: 16'hFFFF, ovr: 1'b0});
    seq = '{10, 12, 10, 13, 13, 11, 11};
    run_pix(2, 64);
    do_ack();

    // Sign map with most-negative samples, then hold without ack.
    sb.push_back('{to: 1'b0, iter: 3, bin: 16'hFF00, ovr: 1'b0});
    do_start();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) y[i] = (i < 8) ? 9'h100 : 9'h000;
      pulse_fs(1'b1);
      if (f != 3) repeat (PERIOD - 1) @(negedge clk);
    end
    wait_done();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_done", {31'd0, done}, 32'd1);
      chk("hold_bin", {16'd0, bin_out}, 32'h0000FF00);
    end
    do_ack();

    // Extra frame_sync 8 cycles into a comparison.
    sb.push_back('{to: 1'b0, iter: 3, bin: 16'hFFFF, ovr: 1'b1});
    set_all(64);
    do_start();
    pulse_fs(1'b1);
    repeat (PERIOD - 1) @(negedge clk);
    pulse_fs(1'b1);
    repeat (7) @(negedge clk);
    pulse_fs(1'b0);
    repeat (PERIOD - 9 - 1) @(negedge clk);
    pulse_fs(1'b1);
    repeat (PERIOD - 1) @(negedge clk);
    pulse_fs(1'b1);
    wait_done();
    do_ack();

    // Reset while comparing pixel index 9.
    set_all(-5);
    do_start();
    pulse_fs(1'b1);
    repeat (PERIOD - 1) @(negedge clk);
    pulse_fs(1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_timeout", {31'd0, timeout}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    chk("midrst_bin", {16'd0, bin_out}, 32'd0);
    chk("midrst_iter", {24'd0, iter_count}, 32'd0);
    pulse_fs(1'b0);
    repeat (20) @(negedge clk);
    chk("idle_ignores_fs", {31'd0, busy | done}, 32'd0);

    // Restart: ack and start together in DONE.
    sb.push_back('{to: 1'b0, iter: 3, bin: 16'hFFFF, ovr: 1'b0});
    seq = '{1, 1, 1, 1};
    run_pix(0, 1);
    ack = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_iter", {24'd0, iter_count}, 32'd0);
    chk("restart_done", {31'd0, done}, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_leftover", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
